// File: rtl/burst_ram_responder.sv
// Burst-RAM command responder: word-addressed internal memory that absorbs write
// bursts and returns read bursts after a fixed latency.
module burst_ram_responder #(
    parameter int unsigned DEPTH_BITWIDTH = 8,
    parameter int unsigned DATA_BITWIDTH  = 64,
    parameter int unsigned BURST_COUNT    = 4,
    parameter int unsigned READ_LATENCY   = 4,
    parameter int unsigned INIT_CYCLES    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd,
    input  logic                       cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]  addr,
    input  logic [DATA_BITWIDTH-1:0]   wr_data,
    input  logic [DATA_BITWIDTH/8-1:0] data_mask,
    output logic [DATA_BITWIDTH-1:0]   rd_data,
    output logic                       rd_data_valid,
    output logic                       busy,
    output logic                       cmd_dropped
);

    localparam int unsigned WORDS   = 2 ** DEPTH_BITWIDTH;
    localparam int unsigned BYTES   = DATA_BITWIDTH / 8;
    localparam int unsigned BEAT_W  = $clog2(BURST_COUNT + 1);
    localparam int unsigned CNT_MAX = (INIT_CYCLES > READ_LATENCY) ? INIT_CYCLES : READ_LATENCY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE,
        READ_WAIT,
        READ_DATA
    } state_t;

    state_t                    state;
    logic [DEPTH_BITWIDTH-1:0] base_addr;
    logic [BEAT_W-1:0]         beat;
    logic [CNT_W-1:0]          cnt;
    logic [DATA_BITWIDTH-1:0]  mem [WORDS];

    logic                      wr_en;
    logic [DEPTH_BITWIDTH-1:0] wr_addr;
    logic [DEPTH_BITWIDTH-1:0] rd_addr;

    // Beat 0 of a write lands in the accept cycle, so its address comes straight from the port.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = base_addr + DEPTH_BITWIDTH'(beat);
        rd_addr = base_addr + DEPTH_BITWIDTH'(beat);
        if (!rst) begin
            if (state == IDLE && cmd_en && cmd) begin
                wr_en   = 1'b1;
                wr_addr = addr;
            end else if (state == WRITE) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (!data_mask[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= INIT;
            base_addr     <= '0;
            beat          <= '0;
            cnt           <= '0;
            busy          <= 1'b1;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            cmd_dropped   <= 1'b0;
        end else begin
            cmd_dropped <= cmd_en && busy;
            case (state)
                INIT: begin
                    if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (cmd_en) begin
                        base_addr <= addr;
                        busy      <= 1'b1;
                        if (cmd) begin
                            beat  <= BEAT_W'(1);
                            state <= WRITE;
                        end else if (READ_LATENCY == 1) begin
                            rd_data       <= mem[addr];
                            rd_data_valid <= 1'b1;
                            beat          <= BEAT_W'(1);
                            state         <= READ_DATA;
                        end else begin
                            beat  <= '0;
                            cnt   <= CNT_W'(1);
                            state <= READ_WAIT;
                        end
                    end
                end
                WRITE: begin
                    if (beat == BEAT_W'(BURST_COUNT - 1)) begin
                        beat  <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                READ_WAIT: begin
                    // cnt tracks the cycle number since accept; beat 0 is registered one cycle early.
                    if (cnt == CNT_W'(READ_LATENCY - 1)) begin
                        rd_data       <= mem[base_addr];
                        rd_data_valid <= 1'b1;
                        beat          <= BEAT_W'(1);
                        cnt           <= '0;
                        state         <= READ_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                READ_DATA: begin
                    if (beat == BEAT_W'(BURST_COUNT)) begin
                        rd_data       <= '0;
                        rd_data_valid <= 1'b0;
                        beat          <= '0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        rd_data <= mem[rd_addr];
                        beat    <= beat + BEAT_W'(1);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_ram_responder.sv
// Directed bench for burst_ram_responder: bench-side memory model feeds a queue of
// expected read beats that a negedge monitor pops and compares.
module tb_burst_ram_responder;

    localparam int L  = 4;
    localparam int B  = 4;
    localparam int IC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd = 1'b0;
    logic        cmd_en = 1'b0;
    logic [7:0]  addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  data_mask = '0;
    logic [63:0] rd_data;
    logic        rd_data_valid;
    logic        busy;
    logic        cmd_dropped;

    typedef struct {
        logic [63:0] data;
        bit          dc;
    } exp_t;

    exp_t        exp_q [$];
    logic [63:0] model [256];
    logic [63:0] wd [4];
    logic [7:0]  wm [4];
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;

    burst_ram_responder #(
        .DEPTH_BITWIDTH(8),
        .DATA_BITWIDTH (64),
        .BURST_COUNT   (B),
        .READ_LATENCY  (L),
        .INIT_CYCLES   (IC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd),
        .cmd_en       (cmd_en),
        .addr         (addr),
        .wr_data      (wr_data),
        .data_mask    (data_mask),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .busy         (busy),
        .cmd_dropped  (cmd_dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_data_valid) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat observed=%h expected=none", rd_data);
                end
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (!e.dc) chk64("rd_beat", rd_data, e.data);
                end
            end else begin
                chk64("rd_data_idle_zero", rd_data, 64'h0);
            end
        end
    end

    // Caller must be in an idle cycle; returns in the cycle the DUT is idle again.
    task automatic do_write(input logic [7:0] a);
        chk1("wr_accept_idle", busy, 1'b0);
        for (int i = 0; i < B; i++) begin
            logic [7:0] wa;
            wa        = a + 8'(i);
            cmd_en    = (i == 0);
            cmd       = 1'b1;
            addr      = a;
            wr_data   = wd[i];
            data_mask = wm[i];
            for (int b = 0; b < 8; b++) begin
                if (!wm[i][b]) model[wa][8*b +: 8] = wd[i][8*b +: 8];
            end
            step();
            if (i < B - 1) chk1("wr_busy", busy, 1'b1);
        end
        cmd_en = 1'b0;
        chk1("wr_done_idle", busy, 1'b0);
    endtask

    task automatic do_read(input logic [7:0] a, input bit dc, input int drop);
        chk1("rd_accept_idle", busy, 1'b0);
        cmd_en = 1'b1;
        cmd    = 1'b0;
        addr   = a;
        for (int i = 0; i < B; i++) begin
            logic [7:0] ra;
            ra = a + 8'(i);
            exp_q.push_back('{data: model[ra], dc: dc});
        end
        step();
        for (int c = 1; c <= L + B; c++) begin
            chk1("rd_busy", busy, c < L + B);
            chk1("rd_valid", rd_data_valid, c >= L && c < L + B);
            chk1("rd_dropped", cmd_dropped, drop != 0 && c == drop + 1);
            if (c < L + B) begin
                cmd_en    = (c == drop);
                cmd       = 1'b1;
                addr      = a;
                wr_data   = 64'hDEAD_BEEF_0BAD_F00D;
                data_mask = '0;
                step();
            end
        end
        cmd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;

        // Reset with a read command held on throughout init.
        rst    = 1'b1;
        cmd_en = 1'b1;
        cmd    = 1'b0;
        addr   = 8'h80;
        step();
        mon_en = 1'b1;
        chk1("rst_busy", busy, 1'b1);
        chk1("rst_valid", rd_data_valid, 1'b0);
        chk64("rst_rd_data", rd_data, 64'h0);
        chk1("rst_dropped", cmd_dropped, 1'b0);
        step();
        rst = 1'b0;
        for (int c = 0; c < IC; c++) begin
            chk1("init_busy", busy, 1'b1);
            chk1("init_dropped", cmd_dropped, c >= 1);
            step();
        end
        chk1("init_done_busy", busy, 1'b0);
        chk1("init_last_dropped", cmd_dropped, 1'b1);
        do_read(8'h80, 1'b1, 0);

        // Plain write then read-back, read issued the cycle the write finishes.
        wd = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        wm = '{8'h00, 8'h00, 8'h00, 8'h00};
        do_write(8'h10);
        do_read(8'h10, 1'b0, 0);

        // Byte mask: only the low four bytes of beat 0 overwritten.
        wd = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        wm = '{8'h00, 8'h00, 8'h00, 8'h00};
        do_write(8'h20);
        wd = '{64'h0, 64'h0, 64'h0, 64'h0};
        wm = '{8'hF0, 8'hFF, 8'hFF, 8'hFF};
        do_write(8'h20);
        chk64("mask_model_beat0", model[8'h20], 64'hFFFF_FFFF_0000_0000);
        do_read(8'h20, 1'b0, 0);

        // Address wrap at the top of memory.
        wd = '{64'h0000_0000_0000_0A00, 64'h0000_0000_0000_0A01,
               64'h0000_0000_0000_0A02, 64'h0000_0000_0000_0A03};
        wm = '{8'h00, 8'h00, 8'h00, 8'h00};
        do_write(8'h00);
        wd = '{64'hAAAA_AAAA_0000_0001, 64'hBBBB_BBBB_0000_0002,
               64'hCCCC_CCCC_0000_0003, 64'hDDDD_DDDD_0000_0004};
        do_write(8'hFE);
        do_read(8'hFE, 1'b0, 0);
        do_read(8'h00, 1'b0, 0);

        // Mixed masks over a freshly filled region.
        ra = 8'($urandom_range(8'h40, 8'h7B));
        wd = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
        wm = '{8'h00, 8'h00, 8'h00, 8'h00};
        do_write(ra);
        wd = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
        wm = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        do_write(ra);
        do_read(ra, 1'b0, 0);

        // Write strobed while a read is in flight must be dropped.
        do_read(8'h10, 1'b0, 3);
        do_read(8'h10, 1'b0, 0);

        // Reset during the second read beat.
        chk1("rr_accept_idle", busy, 1'b0);
        cmd_en = 1'b1;
        cmd    = 1'b0;
        addr   = 8'h10;
        exp_q.push_back('{data: model[8'h10], dc: 1'b0});
        exp_q.push_back('{data: model[8'h11], dc: 1'b0});
        step();
        cmd_en = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk1("rr_valid", rd_data_valid, c >= L);
            if (c == 5) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        for (int k = 0; k < IC; k++) begin
            chk1("rr_init_busy", busy, 1'b1);
            chk1("rr_valid_off", rd_data_valid, 1'b0);
            step();
        end
        chk1("rr_init_done", busy, 1'b0);
        do_read(8'h10, 1'b0, 0);
        do_read(8'h20, 1'b0, 0);

        step();
        step();
        chk64("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/burst_ram_responder.md
# burst_ram_responder

Responder end of the burst-RAM command interface driven by the cache/RAMIO side of the SoC. Accepts single-cycle read/write commands, holds an internal word-addressed memory of `2^DEPTH_BITWIDTH` words, absorbs write bursts and returns read bursts after a fixed latency. It is used as the memory endpoint in simulation and small on-chip builds, in place of the external burst DRAM controller.

## Interface
- `DEPTH_BITWIDTH`, 8, address width; memory holds `2^DEPTH_BITWIDTH` words.
- `DATA_BITWIDTH`, 64, width of one burst beat; must be a multiple of 8.
- `BURST_COUNT`, 4, beats per command (≥2).
- `READ_LATENCY`, 4, cycles from read accept to first valid beat (≥1).
- `INIT_CYCLES`, 8, cycles `busy` stays high after reset (≥1).

- `clk` in 1: clock clk.
- `rst` in 1: reset rst, synchronous, active-high.
- `cmd` in 1: 0 = read, 1 = write; sampled with `cmd_en`.
- `cmd_en` in 1: command strobe, one cycle.
- `addr` in DEPTH_BITWIDTH: start word address of burst.
- `wr_data` in DATA_BITWIDTH: write beat data.
- `data_mask` in DATA_BITWIDTH/8: bit i = 1 masks byte i (byte not written).
- `rd_data` out DATA_BITWIDTH: read beat data.
- `rd_data_valid` out 1: `rd_data` holds a valid beat.
- `busy` out 1: high = command would be dropped.
- `cmd_dropped` out 1: one-cycle pulse, `cmd_en` seen while `busy`.

## Operation
- States: INIT, IDLE, WRITE, READ_WAIT, READ_DATA.
- INIT: entered on reset; counter runs INIT_CYCLES cycles, then IDLE. `busy`=1.
- IDLE: `busy`=0. `cmd_en`=1 accepts command (cycle 0), latches `addr`, beat counter=0.
  - Write: beat 0 (`wr_data`, `data_mask`) written this same cycle to `addr`; -> WRITE.
  - Read: -> READ_WAIT.
- WRITE: beats 1..BURST_COUNT-1 taken on consecutive cycles, one per cycle, no gaps; beat i written to `(addr+i) mod 2^DEPTH_BITWIDTH`, only unmasked bytes. After last beat -> IDLE.
- READ_WAIT: waits until cycle READ_LATENCY, -> READ_DATA.
- READ_DATA: outputs beat i = word `(addr+i) mod 2^DEPTH_BITWIDTH`, i = 0..BURST_COUNT-1, one per cycle; after last -> IDLE.
- Address arithmetic is DEPTH_BITWIDTH wide, wraps silently at top of memory; no alignment required.
- `cmd_en` while `busy`=1 (any non-IDLE state): command ignored, no state change, `cmd_dropped`=1 next cycle.
- Read of a word written by an earlier write burst returns new data; a read accepted in the cycle after a write burst completes sees all its beats.
- Memory contents are not initialised and not cleared by reset.

## Timing
- Reset values: `busy`=1, `rd_data_valid`=0, `rd_data`=0, `cmd_dropped`=0; state INIT.
- After `rst` falls: `busy` high exactly INIT_CYCLES cycles, first command accepted in cycle INIT_CYCLES.
- Write accepted at cycle 0: `busy`=1 cycles 1..BURST_COUNT-1; `busy`=0 at BURST_COUNT; next command accepted at BURST_COUNT earliest.
- Read accepted at cycle 0: `rd_data_valid`=1 cycles READ_LATENCY..READ_LATENCY+BURST_COUNT-1 (registered outputs); `busy`=1 cycles 1..READ_LATENCY+BURST_COUNT-1; next command at READ_LATENCY+BURST_COUNT.
- `rd_data`=0 whenever `rd_data_valid`=0.
- Reset mid-burst: abort immediately; beats already written stay in memory; no further `rd_data_valid`; state INIT next cycle.
- `busy` is registered; it reflects acceptance from the previous cycle, so the initiator must not assert `cmd_en` in a cycle where `busy`=1.

## Test plan
- Init: pulse `rst`, hold `cmd_en`=1 read -> `busy`=1 for 8 cycles, `cmd_dropped` pulses each of those cycles, first accept at cycle 8.
- Write/read: write addr 0x10 beats 0x1111..1, 0x2222..2, 0x3333..3, 0x4444..4, mask 0; read addr 0x10 -> `rd_data_valid` cycles 4–7 with same four words, `busy` low at cycle 8.
- Byte mask: write addr 0x20 all-0xFF words, then write addr 0x20 beat 0 = 0, mask 0xF0 -> read beat 0 = 0xFFFFFFFF_00000000, beats 1–3 unchanged.
- Wrap: write burst at addr 0xFE values A,B,C,D -> read 0xFE returns A,B,C,D; read 0x00 returns C,D then words 0x02,0x03.
- Busy drop: accept read at 0x10, assert write `cmd_en` at cycle 3 -> `cmd_dropped`=1 at cycle 4, memory unchanged, read data intact.
- Reset mid-read: assert `rst` at cycle 5 of read -> `rd_data_valid`=0 from next cycle, `busy`=1 for 8 cycles, earlier-written data still readable afterward.
